div64x32_iter: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/div64x32_arith.sv | 84 ++++++++
 rtl/div64x32_fsm.sv | 88 ++++++++
 rtl/div64x32_iter.sv | 51 +++++
 tb/tb_div64x32_iter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared widths, iteration bounds and state encoding for the 64/32 divider.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 64;
    localparam int unsigned DIVISOR_W  = 32;
    localparam int unsigned ITER_W     = 5;
    localparam int unsigned PR_W       = DIVISOR_W + 1;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIVISOR_W - 1);

    typedef enum logic {
        S_IDLE,
        S_DIVIDE
    } div_state_t;

endpackage

// File: rtl/div64x32_arith.sv
// Restoring-division datapath: operand registers, 33-bit compare/subtract,
// quotient shift register and the held result registers.
module div64x32_arith
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIVIDEND_W-1:0] i_a,
    input  logic [DIVISOR_W-1:0]  i_b,
    input  logic                  i_load,
    input  logic                  i_iter,
    input  logic                  i_finish,
    input  logic                  i_err,
    output logic                  o_div_error_detect_c,
    output logic [DIVISOR_W-1:0]  o_quotient,
    output logic [DIVISOR_W-1:0]  o_remainder,
    output logic                  o_error
);

    logic [PR_W-1:0]      r_pr;
    logic [DIVISOR_W-1:0] r_lo;
    logic [DIVISOR_W-1:0] r_dv;
    logic [DIVISOR_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0] r_remainder;
    logic                 r_error;

    logic [PR_W-1:0]      w_t;
    logic [PR_W-1:0]      w_dv_ext;
    logic                 w_ge;
    logic [PR_W-1:0]      w_pr_nxt;
    logic [DIVISOR_W-1:0] w_lo_nxt;

    // Quotient would not fit in 32 bits, or divisor is zero.
    assign o_div_error_detect_c = (i_b == '0) ||
                                  (i_a[DIVIDEND_W-1:DIVISOR_W] >= i_b);

    // One restoring step: shift in the next dividend bit, trial subtract.
    // A set pr MSB means the shifted value already exceeds any divisor.
    always_comb begin
        w_t      = {r_pr[DIVISOR_W-1:0], r_lo[DIVISOR_W-1]};
        w_dv_ext = {1'b0, r_dv};
        w_ge     = r_pr[PR_W-1] || (w_t >= w_dv_ext);
        w_pr_nxt = w_ge ? (w_t - w_dv_ext) : w_t;
        w_lo_nxt = {r_lo[DIVISOR_W-2:0], w_ge};
    end

    // Working registers: load on accept, update every iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pr <= '0;
            r_lo <= '0;
            r_dv <= '0;
        end else if (i_load) begin
            r_pr <= PR_W'(i_a[DIVIDEND_W-1:DIVISOR_W]);
            r_lo <= i_a[DIVISOR_W-1:0];
            r_dv <= i_b;
        end else if (i_iter) begin
            r_pr <= w_pr_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    // Result registers hold until the next completion or error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_error     <= 1'b0;
        end else if (i_err) begin
            r_quotient  <= '1;
            r_remainder <= '0;
            r_error     <= 1'b1;
        end else if (i_finish) begin
            r_quotient  <= w_lo_nxt;
            r_remainder <= w_pr_nxt[DIVISOR_W-1:0];
            r_error     <= 1'b0;
        end
    end

    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_error     = r_error;

endmodule

// File: rtl/div64x32_fsm.sv
// Sequencer for the divider: accepts start in IDLE, counts 32 iterations,
// raises busy while iterating and pulses done on completion or error.
module div64x32_fsm
    import div_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div_error_detect,
    output logic o_busy,
    output logic o_done,
    output logic o_load_c,
    output logic o_iter_c,
    output logic o_finish_c,
    output logic o_err_c
);

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic [ITER_W-1:0] r_cnt;
    logic [ITER_W-1:0] w_cnt_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        o_load_c    = 1'b0;
        o_iter_c    = 1'b0;
        o_finish_c  = 1'b0;
        o_err_c     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_div_error_detect) begin
                        // Divide-by-zero or overflow finishes immediately.
                        o_err_c    = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        o_load_c    = 1'b1;
                        w_state_nxt = S_DIVIDE;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            S_DIVIDE: begin
                o_iter_c  = 1'b1;
                w_cnt_nxt = r_cnt + ITER_W'(1);
                if (r_cnt == LAST_ITER) begin
                    o_finish_c  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/div64x32_iter.sv
// Iterative unsigned 64-by-32 divider: sequencer plus datapath.
module div64x32_iter
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    logic w_load;
    logic w_iter;
    logic w_finish;
    logic w_err;
    logic w_div_error_detect;

    div64x32_fsm u_fsm (
        .clk                (clk),
        .reset              (reset),
        .i_start            (start),
        .i_div_error_detect (w_div_error_detect),
        .o_busy             (busy),
        .o_done             (done),
        .o_load_c           (w_load),
        .o_iter_c           (w_iter),
        .o_finish_c         (w_finish),
        .o_err_c            (w_err)
    );

    div64x32_arith u_arith (
        .clk                  (clk),
        .reset                (reset),
        .i_a                  (a),
        .i_b                  (b),
        .i_load               (w_load),
        .i_iter               (w_iter),
        .i_finish             (w_finish),
        .i_err                (w_err),
        .o_div_error_detect_c (w_div_error_detect),
        .o_quotient           (quotient),
        .o_remainder          (remainder),
        .o_error              (error)
    );

endmodule

// File: tb/tb_div64x32_iter.sv
// Directed self-checking bench for div64x32_iter.
module tb_div64x32_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div64x32_iter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive operands with start at a falling edge, let the start edge pass,
    // drop start; returns at the cycle-1 sample point.
    task automatic start_op(input logic [63:0] av, input logic [31:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Successful division: done and results exactly at cycle 33.
    task automatic do_div(input string tag, input logic [63:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [31:0] er);
        start_op(av, bv);
        repeat (31) @(negedge clk);
        chk({tag, "_done_c32"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_q"}, 64'(quotient), 64'(eq));
        chk({tag, "_r"}, 64'(remainder), 64'(er));
        chk({tag, "_err"}, 64'(error), 64'd0);
    endtask

    // Error case: results one cycle after start, busy never rises.
    task automatic do_err(input string tag, input logic [63:0] av, input logic [31:0] bv);
        start_op(av, bv);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(error), 64'd1);
        chk({tag, "_q"}, 64'(quotient), 64'hFFFF_FFFF);
        chk({tag, "_r"}, 64'(remainder), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_busy2"}, 64'(busy), 64'd0);
        chk({tag, "_err_hold"}, 64'(error), 64'd1);
    endtask

    initial begin
        int nbusy;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        reset = 1'b0;

        // 100 / 7 with busy traced over every cycle.
        start_op(64'd100, 32'd7);
        nbusy = 0;
        for (int c = 1; c <= 32; c++) begin
            if (busy === 1'b1 && done === 1'b0) nbusy++;
            if (c < 32) @(negedge clk);
        end
        chk("t1_busy_cycles", 64'(nbusy), 64'd32);
        @(negedge clk);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_q", 64'(quotient), 64'd14);
        chk("t1_r", 64'(remainder), 64'd2);
        chk("t1_err", 64'(error), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_q_hold", 64'(quotient), 64'd14);

        // Max multiplier product back to its factors.
        do_div("t2", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

        // Divide by zero, then quotient overflow at the boundary hi==b.
        do_err("t3z", 64'h1234_5678_9ABC_DEF0, 32'd0);
        do_err("t3o", 64'h1_0000_0000, 32'd1);

        // Largest non-overflowing high word (hi = b-1).
        do_div("t3b", 64'h0000_0004_0000_0000, 32'd5, 32'hCCCC_CCCC, 32'd4);

        // Operand change and start re-assert while busy are ignored.
        start_op(64'd12345, 32'd100);
        repeat (4) @(negedge clk);
        a = 64'hDEAD_BEEF_0000_0000;
        b = 32'd0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_c11", 64'(busy), 64'd1);
        repeat (21) @(negedge clk);
        chk("t4_done_c32", 64'(done), 64'd0);
        @(negedge clk);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_q", 64'(quotient), 64'd123);
        chk("t4_r", 64'(remainder), 64'd45);
        @(negedge clk);
        chk("t4_no_restart", 64'(busy), 64'd0);

        // Reset mid-operation aborts; next op runs cleanly.
        start_op(64'd100, 32'd7);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_err", 64'(error), 64'd0);
        chk("t5_q", 64'(quotient), 64'd0);
        chk("t5_r", 64'(remainder), 64'd0);
        do_div("t5n", 64'd9, 32'd3, 32'd3, 32'd0);

        // Back-to-back with start held high through the done cycle.
        @(negedge clk);
        a     = 64'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 64'h0000_0000_FFFF_FFFF;
        b = 32'd2;
        repeat (32) @(negedge clk);
        chk("t6_done1", 64'(done), 64'd1);
        chk("t6_q1", 64'(quotient), 64'd14);
        chk("t6_r1", 64'(remainder), 64'd2);
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy2", 64'(busy), 64'd1);
        repeat (31) @(negedge clk);
        chk("t6_done_c65", 64'(done), 64'd0);
        @(negedge clk);
        chk("t6_done2", 64'(done), 64'd1);
        chk("t6_q2", 64'(quotient), 64'h7FFF_FFFF);
        chk("t6_r2", 64'(remainder), 64'd1);
        chk("t6_err2", 64'(error), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
